// File: rtl/bus_cmd_pkg.sv
// Shared opcodes, status codes and FSM state encoding for the byte-framed bus command master.
package bus_cmd_pkg;

  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BUS_ERR = 8'h01;
  localparam logic [7:0] ST_TIMEOUT = 8'h02;
  localparam logic [7:0] ST_BAD_OP  = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    BUS,
    RESP
  } state_e;

  function automatic logic is_legal_op(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/bus_protocol_if.sv
// Simple single-beat memory-mapped bus: manager drives the request, peripheral may stall it.
interface bus_protocol_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    ren;
  logic                    wen;
  logic [DATA_WIDTH/8-1:0] strobe;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    error;
  logic                    request_stall;

  modport protocol (
    output addr, wdata, ren, wen, strobe,
    input  rdata, error, request_stall
  );

  modport peripheral (
    input  addr, wdata, ren, wen, strobe,
    output rdata, error, request_stall
  );
endinterface

// File: rtl/bus_cmd_master_byte_serializer.sv
// Loads a status+data word and shifts it out MSB byte first under a valid/ready handshake.
module byte_serializer #(
  parameter int NBYTES = 5
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  load_i,
  input  logic [8*NBYTES-1:0]   word_i,
  input  logic [7:0]            len_i,
  input  logic                  tx_ready_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  output logic                  done_o
);

  logic [8*NBYTES-1:0] shreg_q;
  logic [7:0]          left_q;
  logic                valid_q;
  logic                handshake;

  assign handshake  = valid_q && tx_ready_i;
  assign tx_data_o  = shreg_q[8*NBYTES-1 -: 8];
  assign tx_valid_o = valid_q;
  assign done_o     = handshake && (left_q == 8'd1);

  // The front byte only moves on a completed handshake, so tx_data holds under backpressure.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      shreg_q <= '0;
      left_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      shreg_q <= word_i;
      left_q  <= len_i;
      valid_q <= (len_i != 8'd0);
    end else if (handshake) begin
      shreg_q <= shreg_q << 8;
      left_q  <= left_q - 8'd1;
      if (left_q == 8'd1) valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/bus_cmd_master.sv
// Byte-stream command decoder that issues single bus reads/writes and streams back a status response.
module bus_cmd_master
  import bus_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  bus_protocol_if.protocol bus_if
);

  localparam int AB = ADDR_WIDTH / 8;
  localparam int DB = DATA_WIDTH / 8;
  localparam int RW = 8 * (DB + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e                  state_q;
  logic [7:0]              byte_cnt_q;
  logic                    is_write_q;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    ren_q, wen_q;
  logic [DB-1:0]           strobe_q;
  logic [TW-1:0]           tmo_q;
  logic                    rx_ready_q;
  logic                    ser_load_q;
  logic [RW-1:0]           ser_word_q, resp_word_d;
  logic [7:0]              ser_len_q, resp_len_d;
  logic                    ser_done;
  logic                    rx_fire, last_addr, last_data, tmo_expired;

  assign rx_fire     = rx_valid && rx_ready_q;
  assign addr_d      = (addr_q << 8) | ADDR_WIDTH'(rx_data);
  assign wdata_d     = (wdata_q << 8) | DATA_WIDTH'(rx_data);
  assign last_addr   = (byte_cnt_q == 8'(AB - 1));
  assign last_data   = (byte_cnt_q == 8'(DB - 1));
  assign tmo_expired = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  assign rx_ready       = rx_ready_q;
  assign bus_if.addr    = addr_q;
  assign bus_if.wdata   = wdata_q;
  assign bus_if.ren     = ren_q;
  assign bus_if.wen     = wen_q;
  assign bus_if.strobe  = strobe_q;

  // Response chosen on the completing bus cycle; only a clean read carries data bytes.
  always_comb begin
    resp_word_d = {ST_OK, bus_if.rdata};
    resp_len_d  = 8'(DB + 1);
    if (bus_if.error) begin
      resp_word_d = {ST_BUS_ERR, {DATA_WIDTH{1'b0}}};
      resp_len_d  = 8'd1;
    end else if (is_write_q) begin
      resp_word_d = {ST_OK, {DATA_WIDTH{1'b0}}};
      resp_len_d  = 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      strobe_q   <= '0;
      tmo_q      <= '0;
      rx_ready_q <= 1'b0;
      ser_load_q <= 1'b0;
      ser_word_q <= '0;
      ser_len_q  <= '0;
    end else begin
      ser_load_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rx_ready_q <= 1'b1;
          if (rx_fire) begin
            byte_cnt_q <= '0;
            is_write_q <= (rx_data == OP_WRITE);
            if (is_legal_op(rx_data)) begin
              state_q <= ADDR;
            end else begin
              state_q    <= RESP;
              rx_ready_q <= 1'b0;
              ser_load_q <= 1'b1;
              ser_word_q <= {ST_BAD_OP, {DATA_WIDTH{1'b0}}};
              ser_len_q  <= 8'd1;
            end
          end
        end
        ADDR: begin
          if (rx_fire) begin
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_q + 8'd1;
            if (last_addr) begin
              byte_cnt_q <= '0;
              if (is_write_q) begin
                state_q <= WDATA;
              end else begin
                state_q    <= BUS;
                rx_ready_q <= 1'b0;
                ren_q      <= 1'b1;
                strobe_q   <= '1;
                tmo_q      <= '0;
              end
            end
          end
        end
        WDATA: begin
          if (rx_fire) begin
            wdata_q    <= wdata_d;
            byte_cnt_q <= byte_cnt_q + 8'd1;
            if (last_data) begin
              byte_cnt_q <= '0;
              state_q    <= BUS;
              rx_ready_q <= 1'b0;
              wen_q      <= 1'b1;
              strobe_q   <= '1;
              tmo_q      <= '0;
            end
          end
        end
        BUS: begin
          if (!bus_if.request_stall) begin
            ren_q      <= 1'b0;
            wen_q      <= 1'b0;
            strobe_q   <= '0;
            state_q    <= RESP;
            ser_load_q <= 1'b1;
            ser_word_q <= resp_word_d;
            ser_len_q  <= resp_len_d;
          end else if (tmo_expired) begin
            ren_q      <= 1'b0;
            wen_q      <= 1'b0;
            strobe_q   <= '0;
            state_q    <= RESP;
            ser_load_q <= 1'b1;
            ser_word_q <= {ST_TIMEOUT, {DATA_WIDTH{1'b0}}};
            ser_len_q  <= 8'd1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        RESP: begin
          if (ser_done) begin
            state_q    <= IDLE;
            rx_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  byte_serializer #(.NBYTES(DB + 1)) u_ser (
    .clk        (clk),
    .n_rst      (n_rst),
    .load_i     (ser_load_q),
    .word_i     (ser_word_q),
    .len_i      (ser_len_q),
    .tx_ready_i (tx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .done_o     (ser_done)
  );

endmodule

// File: tb/tb_bus_cmd_master.sv
// Directed bench for bus_cmd_master: framing, stalls, timeout, errors, backpressure and reset.
module tb_bus_cmd_master;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  bus_protocol_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  bus_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .bus_if   (bus)
  );

  always #5 clk = ~clk;

  // Peripheral model: stalls the first stall_n cycles of each transfer, or forever.
  logic [31:0] p_rdata = 32'h0;
  logic        p_error = 1'b0;
  int          stall_n = 0;
  bit          stall_forever = 1'b0;
  int          busy_cnt = 0;

  assign bus.rdata         = p_rdata;
  assign bus.error         = p_error;
  assign bus.request_stall = stall_forever || (busy_cnt < stall_n);

  always @(posedge clk) busy_cnt <= (bus.ren || bus.wen) ? busy_cnt + 1 : 0;

  int          ren_cyc = 0;
  int          wen_cyc = 0;
  logic [31:0] mon_addr = '0;
  logic [31:0] mon_wdata = '0;
  logic [3:0]  mon_strb = '0;

  always @(negedge clk) begin
    if (bus.ren) begin
      ren_cyc  <= ren_cyc + 1;
      mon_addr <= bus.addr;
      mon_strb <= bus.strobe;
    end
    if (bus.wen) begin
      wen_cyc   <= wen_cyc + 1;
      mon_addr  <= bus.addr;
      mon_wdata <= bus.wdata;
      mon_strb  <= bus.strobe;
    end
  end

  logic [7:0] txlog [0:255];
  int         tx_cnt = 0;

  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      txlog[tx_cnt[7:0]] <= tx_data;
      tx_cnt             <= tx_cnt + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (!rx_ready) begin
      n_err++;
      $display("FAIL rx_accept: byte %h not accepted, rx_ready=%b required 1", b, rx_ready);
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h01);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
  endtask

  task automatic wait_tx(input int target, output bit ok);
    int t;
    t = 0;
    while (tx_cnt < target && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    ok = (tx_cnt >= target);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({rx_ready, tx_valid, bus.ren, bus.wen} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctrl: rx_ready/tx_valid/ren/wen=%b required 0000",
               {rx_ready, tx_valid, bus.ren, bus.wen});
    end
    n_cmp++;
    if ({tx_data, bus.addr, bus.wdata, bus.strobe} !== 76'h0) begin
      n_err++;
      $display("FAIL reset_data: tx_data=%h addr=%h wdata=%h strobe=%h required all 0",
               tx_data, bus.addr, bus.wdata, bus.strobe);
    end
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (rx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_idle_ready: rx_ready=%b required 1", rx_ready);
    end
  endtask

  task automatic test_read();
    int  rb, wb, tb0;
    bit  ok;
    logic [7:0] exp [0:4];
    exp = '{8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    rb = ren_cyc; wb = wen_cyc; tb0 = tx_cnt;
    p_rdata = 32'hDEADBEEF; stall_n = 0;
    send_read(32'h0000_1000);
    wait_tx(tb0 + 5, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL read_tx_count: got %0d bytes required 5", tx_cnt - tb0); end
    n_cmp++;
    if (rx_ready !== 1'b1) begin n_err++; $display("FAIL read_ready_after: rx_ready=%b required 1", rx_ready); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (txlog[8'(tb0 + i)] !== exp[i]) begin
        n_err++;
        $display("FAIL read_tx_byte%0d: got %h required %h", i, txlog[8'(tb0 + i)], exp[i]);
      end
    end
    n_cmp++;
    if (ren_cyc - rb !== 1 || wen_cyc - wb !== 0) begin
      n_err++;
      $display("FAIL read_strobes: ren cycles %0d wen cycles %0d required 1 and 0", ren_cyc - rb, wen_cyc - wb);
    end
    n_cmp++;
    if (mon_addr !== 32'h0000_1000 || mon_strb !== 4'hF) begin
      n_err++;
      $display("FAIL read_addr: addr=%h strobe=%h required 00001000 f", mon_addr, mon_strb);
    end
  endtask

  task automatic test_write_stall();
    int  rb, wb, tb0;
    bit  ok;
    logic [7:0] frame [0:8];
    frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h04, 8'h12, 8'h34, 8'h56, 8'h78};
    rb = ren_cyc; wb = wen_cyc; tb0 = tx_cnt;
    stall_n = 3;
    for (int i = 0; i < 9; i++) send_byte(frame[i]);
    wait_tx(tb0 + 1, ok);
    repeat (6) @(posedge clk);
    #1;
    stall_n = 0;
    n_cmp++;
    if (!ok || tx_cnt - tb0 !== 1 || txlog[8'(tb0)] !== 8'h00) begin
      n_err++;
      $display("FAIL write_resp: %0d bytes first=%h required 1 byte 00", tx_cnt - tb0, txlog[8'(tb0)]);
    end
    n_cmp++;
    if (wen_cyc - wb !== 4 || ren_cyc - rb !== 0) begin
      n_err++;
      $display("FAIL write_wen_len: wen cycles %0d ren cycles %0d required 4 and 0", wen_cyc - wb, ren_cyc - rb);
    end
    n_cmp++;
    if (mon_wdata !== 32'h12345678 || mon_addr !== 32'h4) begin
      n_err++;
      $display("FAIL write_payload: wdata=%h addr=%h required 12345678 00000004", mon_wdata, mon_addr);
    end
  endtask

  task automatic test_bad_op();
    int  rb, wb, tb0;
    bit  ok;
    logic [7:0] exp [0:4];
    exp = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    rb = ren_cyc; wb = wen_cyc; tb0 = tx_cnt;
    send_byte(8'h7A);
    wait_tx(tb0 + 1, ok);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (!ok || tx_cnt - tb0 !== 1 || txlog[8'(tb0)] !== 8'hFF) begin
      n_err++;
      $display("FAIL badop_resp: %0d bytes first=%h required 1 byte ff", tx_cnt - tb0, txlog[8'(tb0)]);
    end
    n_cmp++;
    if (ren_cyc - rb !== 0 || wen_cyc - wb !== 0) begin
      n_err++;
      $display("FAIL badop_no_bus: ren %0d wen %0d required 0 and 0", ren_cyc - rb, wen_cyc - wb);
    end
    tb0 = tx_cnt;
    p_rdata = 32'h01020304;
    send_read(32'h0000_0008);
    wait_tx(tb0 + 5, ok);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (!ok || txlog[8'(tb0 + i)] !== exp[i]) begin
        n_err++;
        $display("FAIL badop_next_byte%0d: got %h required %h", i, txlog[8'(tb0 + i)], exp[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int rb, tb0;
    bit ok;
    rb = ren_cyc; tb0 = tx_cnt;
    stall_forever = 1'b1;
    send_read(32'h0000_0020);
    wait_tx(tb0 + 1, ok);
    repeat (4) @(posedge clk);
    #1;
    stall_forever = 1'b0;
    n_cmp++;
    if (ren_cyc - rb !== 4) begin
      n_err++;
      $display("FAIL timeout_ren_len: ren cycles %0d required 4", ren_cyc - rb);
    end
    n_cmp++;
    if (!ok || tx_cnt - tb0 !== 1 || txlog[8'(tb0)] !== 8'h02) begin
      n_err++;
      $display("FAIL timeout_resp: %0d bytes first=%h required 1 byte 02", tx_cnt - tb0, txlog[8'(tb0)]);
    end
  endtask

  task automatic test_bus_error();
    int tb0;
    bit ok;
    tb0 = tx_cnt;
    p_error = 1'b1;
    p_rdata = 32'hA5A5A5A5;
    send_read(32'h0000_0030);
    wait_tx(tb0 + 1, ok);
    repeat (6) @(posedge clk);
    #1;
    p_error = 1'b0;
    n_cmp++;
    if (!ok || tx_cnt - tb0 !== 1 || txlog[8'(tb0)] !== 8'h01) begin
      n_err++;
      $display("FAIL buserr_resp: %0d bytes first=%h required 1 byte 01", tx_cnt - tb0, txlog[8'(tb0)]);
    end
  endtask

  task automatic test_backpressure();
    int tb0, t, bad;
    bit ok;
    logic [7:0] exp [0:4];
    exp = '{8'h00, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    tb0 = tx_cnt;
    p_rdata = 32'hCAFEF00D;
    tx_ready = 1'b0;
    send_read(32'h0000_0040);
    t = 0;
    while (!tx_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'h00) bad++;
    end
    n_cmp++;
    if (bad != 0 || t >= 50) begin
      n_err++;
      $display("FAIL bp_hold: %0d cycles with tx_valid/tx_data off, last tx_data=%h required 00", bad, tx_data);
    end
    tx_ready = 1'b1;
    wait_tx(tb0 + 5, ok);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (!ok || txlog[8'(tb0 + i)] !== exp[i]) begin
        n_err++;
        $display("FAIL bp_byte%0d: got %h required %h", i, txlog[8'(tb0 + i)], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_bus();
    int rb, tb0, t;
    bit ok;
    tb0 = tx_cnt;
    stall_forever = 1'b1;
    send_read(32'h0000_0050);
    t = 0;
    while (!bus.ren && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.ren !== 1'b0 || tx_valid !== 1'b0 || t >= 50) begin
      n_err++;
      $display("FAIL midrst_ren: ren=%b tx_valid=%b required 0 0", bus.ren, tx_valid);
    end
    stall_forever = 1'b0;
    n_rst = 1'b1;
    rb = ren_cyc;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (ren_cyc - rb !== 0 || tx_cnt - tb0 !== 0) begin
      n_err++;
      $display("FAIL midrst_quiet: ren cycles %0d tx bytes %0d required 0 0", ren_cyc - rb, tx_cnt - tb0);
    end
    p_rdata = 32'h55AA0FF0;
    send_read(32'h0000_0054);
    wait_tx(tb0 + 5, ok);
    n_cmp++;
    if (!ok || txlog[8'(tb0)] !== 8'h00 || txlog[8'(tb0 + 1)] !== 8'h55 || txlog[8'(tb0 + 4)] !== 8'hF0) begin
      n_err++;
      $display("FAIL midrst_fresh: bytes %h %h .. %h required 00 55 .. f0",
               txlog[8'(tb0)], txlog[8'(tb0 + 1)], txlog[8'(tb0 + 4)]);
    end
    n_cmp++;
    if (ren_cyc - rb !== 1 || mon_addr !== 32'h54) begin
      n_err++;
      $display("FAIL midrst_fresh_bus: ren cycles %0d addr %h required 1 00000054", ren_cyc - rb, mon_addr);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_stall();
    test_bad_op();
    test_timeout();
    test_bus_error();
    test_backpressure();
    test_reset_mid_bus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
